// File: rtl/uart_responder_if.sv
// CPU data-bus port of the UART responder: register select, write data and byte strobes,
// read strobe, registered read data and level interrupt.
interface uart_responder_if;
    logic [2:0]  i_addr;
    logic [31:0] i_din;
    logic [3:0]  i_wr_en;
    logic        i_rd_en;
    logic [31:0] o_dout;
    logic        o_irq;

    modport master (output i_addr, i_din, i_wr_en, i_rd_en, input o_dout, o_irq);
    modport slave  (input i_addr, i_din, i_wr_en, i_rd_en, output o_dout, o_irq);
endinterface

// File: rtl/uart_responder.sv
// Small synchronous FIFO: power-of-2 depth, extra pointer bit gives full/empty.
// Latency: pushed data readable at pop_dat the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module uart_responder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = i_clk_en & pop_rdy & ~empty;
        do_push  = i_clk_en & push_vld & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
endmodule

// Memory-mapped 8N1 UART with TX/RX FIFOs, four registers and a level interrupt.
// Latency: read data one cycle after strobe; TX start bit two cycles after a DATA write.
// Backpressure: none on the bus; TX writes to a full FIFO and RX bytes into a full FIFO drop.
module uart_responder #(
    parameter int          TX_DEPTH  = 4,
    parameter int          RX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    uart_responder_if.slave bus,
    input  logic            i_rxd,
    output logic            o_txd
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    tx_state_t   tx_state_q, tx_state_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] baud_q, baud_d, tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
    logic [15:0] rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [2:0]  rx_sync_q, rx_sync_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic        txd_q, txd_d, irq_q, irq_d;
    logic [31:0] dout_q, dout_d;

    logic        tx_full, tx_empty, rx_full, rx_empty, tx_idle;
    logic [7:0]  tx_head, rx_head;
    logic        tx_push, tx_pop, rx_push, rx_pop, wr_cyc;
    logic        tx_tick, rx_tick, rx_in;
    logic [16:0] rx_half;
    logic        unused_bits;

    // Address bit 2 aliases and the upper write-data half has no register behind it.
    assign unused_bits = ^{bus.i_addr[2], bus.i_din[31:16]};

    uart_responder_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .push_vld(tx_push), .push_dat(bus.i_din[7:0]), .pop_rdy(tx_pop),
        .pop_dat(tx_head), .full(tx_full), .empty(tx_empty));

    uart_responder_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .push_vld(rx_push), .push_dat(rx_shift_q), .pop_rdy(rx_pop),
        .pop_dat(rx_head), .full(rx_full), .empty(rx_empty));

    always_comb begin
        baud_d = baud_q;  ctrl_d = ctrl_q;  overrun_d = overrun_q;  frame_err_d = frame_err_q;
        dout_d = dout_q;  txd_d = txd_q;
        tx_state_d = tx_state_q;  tx_div_d = tx_div_q;  tx_cnt_d = tx_cnt_q;
        tx_shift_d = tx_shift_q;  tx_bit_d = tx_bit_q;
        rx_state_d = rx_state_q;  rx_div_d = rx_div_q;  rx_cnt_d = rx_cnt_q;
        rx_shift_d = rx_shift_q;  rx_bit_d = rx_bit_q;
        rx_sync_d  = {rx_sync_q[1:0], i_rxd};
        rx_in      = rx_sync_q[1];
        tx_idle    = tx_empty & (tx_state_q == TX_IDLE);
        tx_tick    = (tx_cnt_q == tx_div_q);
        rx_tick    = (rx_cnt_q == rx_div_q);
        rx_half    = ({1'b0, rx_div_q} + 17'd1) >> 1;
        wr_cyc     = |bus.i_wr_en;
        tx_push    = wr_cyc & bus.i_wr_en[0] & (bus.i_addr[1:0] == 2'd0);
        rx_pop     = bus.i_rd_en & (bus.i_addr[1:0] == 2'd0) & ~rx_empty;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;

        // Reads see the pre-write register values of this cycle.
        if (bus.i_rd_en) begin
            case (bus.i_addr[1:0])
                2'd0:    dout_d = rx_empty ? 32'd0 : {24'd0, rx_head};
                2'd1:    dout_d = {26'd0, frame_err_q, overrun_q, rx_full, ~rx_empty, tx_idle, tx_full};
                2'd2:    dout_d = {30'd0, ctrl_q};
                default: dout_d = {16'd0, baud_q};
            endcase
        end
        if (wr_cyc) begin
            case (bus.i_addr[1:0])
                2'd1: if (bus.i_wr_en[0]) begin
                    if (bus.i_din[4]) overrun_d   = 1'b0;
                    if (bus.i_din[5]) frame_err_d = 1'b0;
                end
                2'd2: if (bus.i_wr_en[0]) ctrl_d = bus.i_din[1:0];
                2'd3: begin
                    if (bus.i_wr_en[0]) baud_d[7:0]  = bus.i_din[7:0];
                    if (bus.i_wr_en[1]) baud_d[15:8] = bus.i_din[15:8];
                end
                default: ;
            endcase
        end

        // Each bit latches the divider at its start so BAUD writes land on bit boundaries.
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_tick ? 16'd0 : tx_cnt_q + 16'd1;
            if (tx_tick) tx_div_d = baud_q;
        end
        case (tx_state_q)
            TX_IDLE: if (!tx_empty) begin
                tx_pop = 1'b1;  tx_shift_d = tx_head;  tx_cnt_d = '0;  tx_div_d = baud_q;
                txd_d = 1'b0;   tx_state_d = TX_START;
            end
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;  tx_bit_d = '0;
                txd_d = tx_shift_q[0];  tx_shift_d = {1'b0, tx_shift_q[7:1]};
            end
            TX_DATA: if (tx_tick) begin
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = TX_STOP;  txd_d = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    txd_d = tx_shift_q[0];  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            default: if (tx_tick) begin
                if (!tx_empty) begin
                    tx_pop = 1'b1;  tx_shift_d = tx_head;  txd_d = 1'b0;  tx_state_d = TX_START;
                end else begin
                    txd_d = 1'b1;  tx_state_d = TX_IDLE;
                end
            end
        endcase

        case (rx_state_q)
            RX_IDLE: if (rx_sync_q[2] & ~rx_in) begin
                rx_state_d = RX_START;  rx_cnt_d = '0;  rx_div_d = baud_q;
            end
            RX_START: begin
                rx_cnt_d = rx_cnt_q + 16'd1;
                if ({1'b0, rx_cnt_q} == rx_half) begin
                    rx_state_d = rx_in ? RX_IDLE : RX_DATA;
                    rx_cnt_d = '0;  rx_bit_d = '0;  rx_div_d = baud_q;
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_tick ? 16'd0 : rx_cnt_q + 16'd1;
                if (rx_tick) begin
                    rx_shift_d = {rx_in, rx_shift_q[7:1]};
                    rx_div_d   = baud_q;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                rx_cnt_d = rx_tick ? 16'd0 : rx_cnt_q + 16'd1;
                if (rx_tick) begin
                    if (!rx_in) begin
                        frame_err_d = 1'b1;  rx_state_d = RX_WAIT;
                    end else begin
                        if (!rx_full || rx_pop) rx_push = 1'b1;
                        else                    overrun_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            default: if (rx_in) rx_state_d = RX_IDLE;
        endcase

        irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            baud_q <= DIV_RESET;  ctrl_q <= '0;  overrun_q <= 1'b0;  frame_err_q <= 1'b0;
            dout_q <= '0;  txd_q <= 1'b1;  irq_q <= 1'b0;  rx_sync_q <= '1;
            tx_state_q <= TX_IDLE;  tx_div_q <= '0;  tx_cnt_q <= '0;  tx_shift_q <= '0;  tx_bit_q <= '0;
            rx_state_q <= RX_IDLE;  rx_div_q <= '0;  rx_cnt_q <= '0;  rx_shift_q <= '0;  rx_bit_q <= '0;
        end else if (i_clk_en) begin
            baud_q <= baud_d;  ctrl_q <= ctrl_d;  overrun_q <= overrun_d;  frame_err_q <= frame_err_d;
            dout_q <= dout_d;  txd_q <= txd_d;  irq_q <= irq_d;  rx_sync_q <= rx_sync_d;
            tx_state_q <= tx_state_d;  tx_div_q <= tx_div_d;  tx_cnt_q <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;  tx_bit_q <= tx_bit_d;
            rx_state_q <= rx_state_d;  rx_div_q <= rx_div_d;  rx_cnt_q <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;  rx_bit_q <= rx_bit_d;
        end
    end

    assign bus.o_dout = dout_q;
    assign bus.o_irq  = irq_q;
    assign o_txd      = txd_q;
endmodule

// File: tb/tb_uart_responder.sv
// Randomized scoreboard bench for uart_responder: CPU reads and serial TX frames are
// predicted into queues and checked by independent monitors.
module tb_uart_responder;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;

    logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1, rxd = 1'b1;
    wire  txd;
    uart_responder_if bus();

    uart_responder #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .DIV_RESET(16'd433)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .bus(bus), .i_rxd(rxd), .o_txd(txd));

    always #5 clk = ~clk;

    typedef struct {string name; logic [31:0] val;} rd_exp_t;
    rd_exp_t     exp_rd_q[$];
    logic [7:0]  exp_tx_q[$];
    int          tx_starts[$];
    logic [7:0]  rx_m[$];
    bit          ov_m = 0, fe_m = 0, tx_mon_en = 0;
    int          tests = 0, fails = 0, cyc = 0, tb_baud = 433;
    logic [31:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic cpu(input logic [2:0] a, input logic [31:0] d, input logic [3:0] we,
                       input bit rd, input string name, input logic [31:0] exp);
        rd_exp_t e;
        bus.i_addr = a; bus.i_din = d; bus.i_wr_en = we; bus.i_rd_en = rd;
        if (rd && clk_en) begin
            e.name = name; e.val = exp;
            exp_rd_q.push_back(e);
            last_rd = exp;
        end
        tick(1);
        bus.i_wr_en = '0; bus.i_rd_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] we);
        cpu(a, d, we, 1'b0, "", '0);
    endtask

    task automatic rd(input logic [2:0] a, input string name, input logic [31:0] exp);
        cpu(a, '0, 4'b0000, 1'b1, name, exp);
    endtask

    // STATUS as the register map defines it, from the bench's own view of the UART.
    function automatic logic [31:0] st(input bit txf, input bit txi);
        return {26'd0, fe_m, ov_m, rx_m.size() == RX_DEPTH, rx_m.size() != 0, txi, txf};
    endfunction

    task automatic rd_data(input string name);
        logic [31:0] e;
        e = (rx_m.size() != 0) ? {24'd0, rx_m.pop_front()} : 32'd0;
        rd(3'd0, name, e);
    endtask

    task automatic set_baud(input int b);
        wr(3'd3, b, 4'b0011);
        tb_baud = b;
        rd(3'd3, "baud_rb", b);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin rxd = f[i]; tick(tb_baud + 1); end
        rxd = 1'b1;
        tick(2 * (tb_baud + 1));
        if (!stop) fe_m = 1;
        else if (rx_m.size() < RX_DEPTH) rx_m.push_back(b);
        else ov_m = 1;
    endtask

    // Read monitor: o_dout is due the cycle after an enabled read strobe.
    initial begin
        bit p;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            p = bus.i_rd_en && clk_en && !rst;
            @(negedge clk);
            if (p) begin
                if (exp_rd_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rd_unexpected: got 0x%08h with nothing predicted", bus.o_dout);
                end else begin
                    e = exp_rd_q.pop_front();
                    check(e.name, bus.o_dout, e.val);
                end
            end
        end
    end

    // TX monitor: every cycle of a frame must carry the predicted start/data/stop level.
    initial begin
        logic [7:0] b;
        logic [9:0] f, got;
        int p, bad;
        forever begin
            @(negedge clk);
            if (tx_mon_en && txd === 1'b0) begin
                tx_starts.push_back(cyc);
                p = tb_baud + 1;
                if (exp_tx_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL tx_unexpected_frame: start bit seen at cycle %0d, none predicted", cyc);
                    repeat (10 * p - 1) @(negedge clk);
                end else begin
                    b = exp_tx_q.pop_front();
                    f = {1'b1, b, 1'b0};
                    got = '0; bad = 0;
                    for (int i = 0; i < 10 && tx_mon_en; i++)
                        for (int j = 0; j < p && tx_mon_en; j++) begin
                            if (i != 0 || j != 0) @(negedge clk);
                            if (txd !== f[i]) bad++;
                            if (j == p / 2) got[i] = txd;
                        end
                    if (tx_mon_en) begin
                        check("tx_frame", {22'd0, got}, {22'd0, f});
                        check("tx_bit_timing_errs", bad, 0);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc, p;
        logic [7:0] b;
        bus.i_addr = '0; bus.i_din = '0; bus.i_wr_en = '0; bus.i_rd_en = 1'b0;
        tick(3);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, bus.o_irq}, 32'd0);
        check("rst_dout", bus.o_dout, 32'd0);
        rst = 1'b0;
        tick(2);
        tx_mon_en = 1;
        rd(3'd1, "rst_status", st(0, 1));
        rd(3'd2, "rst_ctrl", 32'd0);
        rd(3'd3, "rst_baud", 32'd433);
        rd(3'd0, "rd_empty_data", 32'd0);

        // Upper BAUD lane only; lower lane (0xB1 of 433) must survive. Addr bit 2 aliases.
        wr(3'd7, 32'hFFFF_AB07, 4'b0010);
        rd(3'd3, "baud_lane1", 32'h0000_ABB1);
        set_baud(3);

        exp_tx_q.push_back(8'hA5);
        wr(3'd0, 32'h0000_00A5, 4'b0001);
        tick(10 * 4 + 10);
        check("tx_a5_drained", exp_tx_q.size(), 0);
        rd(3'd1, "tx_idle_after", st(0, 1));

        // Back-to-back bursts: one byte goes straight to the shifter, DEPTH more fit.
        for (int r = 0; r < 3; r++) begin
            n = (r == 0) ? 6 : $urandom_range(1, 7);
            if (r != 0) set_baud($urandom_range(3, 6));
            p = tb_baud + 1;
            acc = (n < TX_DEPTH + 1) ? n : TX_DEPTH + 1;
            tx_starts.delete();
            for (int k = 0; k < n; k++) begin
                b = (r == 0) ? 8'(k + 1) : 8'($urandom);
                if (k < acc) exp_tx_q.push_back(b);
                wr(3'd0, {24'd0, b}, 4'b0001);
            end
            rd(3'd1, "tx_burst_status", st(n >= TX_DEPTH + 1, 0));
            tick(acc * 10 * p + 8);
            check("tx_burst_frames", tx_starts.size(), acc);
            for (int k = 1; k < tx_starts.size(); k++)
                check("tx_b2b_gap", tx_starts[k] - tx_starts[k-1], 10 * p);
            check("tx_burst_drained", exp_tx_q.size(), 0);
            rd(3'd1, "tx_burst_idle", st(0, 1));
        end

        set_baud(7);
        for (int r = 0; r < 3; r++) begin
            send_frame((r == 0) ? 8'h3C : 8'($urandom), 1'b1);
            rd(3'd1, "rx_avail_status", st(0, 1));
            rd_data("rx_data");
            rd(3'd1, "rx_popped_status", st(0, 1));
        end

        for (int k = 0; k < 5; k++) send_frame(8'($urandom), 1'b1);
        rd(3'd1, "rx_overrun_status", st(0, 1));
        for (int k = 0; k < 5; k++) rd_data("rx_fifo_order");
        wr(3'd1, 32'h10, 4'b0001); ov_m = 0;
        rd(3'd1, "overrun_cleared", st(0, 1));

        send_frame(8'($urandom), 1'b0);
        rd(3'd1, "frame_err_status", st(0, 1));
        wr(3'd1, 32'h20, 4'b0001); fe_m = 0;
        rxd = 1'b0; tick(1); rxd = 1'b1; tick(30);
        rd(3'd1, "glitch_status", st(0, 1));
        send_frame(8'($urandom), 1'b1);
        rd_data("rx_after_glitch");

        // Simultaneous read and write returns the old CTRL value.
        cpu(3'd2, 32'h3, 4'b0001, 1'b1, "ctrl_rd_wr_same", 32'd0);
        rd(3'd2, "ctrl_after_wr", 32'd3);
        wr(3'd2, 32'h1, 4'b0001);
        tick(3);
        check("irq_rx_none", {31'd0, bus.o_irq}, 32'd0);
        send_frame(8'($urandom), 1'b1);
        check("irq_rx_avail", {31'd0, bus.o_irq}, 32'd1);
        rd_data("irq_pop");
        tick(2);
        check("irq_after_pop", {31'd0, bus.o_irq}, 32'd0);
        wr(3'd2, 32'h2, 4'b0001);
        tick(2);
        check("irq_tx_idle", {31'd0, bus.o_irq}, 32'd1);

        exp_tx_q.push_back(8'h00);
        wr(3'd0, 32'h0, 4'b0001);
        tick(5);
        check("irq_tx_busy", {31'd0, bus.o_irq}, 32'd0);
        tick(10);
        check("mid_frame_txd_low", {31'd0, txd}, 32'd0);
        tx_mon_en = 0;
        rst = 1'b1; tick(1);
        check("rst_mid_txd", {31'd0, txd}, 32'd1);
        check("rst_mid_irq", {31'd0, bus.o_irq}, 32'd0);
        rst = 1'b0;
        exp_tx_q.delete(); rx_m.delete(); ov_m = 0; fe_m = 0; tb_baud = 433;
        tick(1);
        rd(3'd1, "rst_mid_status", st(0, 1));
        rd(3'd2, "rst_mid_ctrl", 32'd0);
        rd(3'd3, "rst_mid_baud", 32'd433);

        set_baud(3);
        tx_mon_en = 1;
        clk_en = 1'b0;
        wr(3'd0, 32'h55, 4'b0001);
        wr(3'd2, 32'h3, 4'b0001);
        wr(3'd3, 32'h1, 4'b0011);
        rd(3'd1, "", 32'd0);
        rxd = 1'b0;
        tick(20);
        check("hold_dout", bus.o_dout, last_rd);
        check("hold_txd", {31'd0, txd}, 32'd1);
        rxd = 1'b1; clk_en = 1'b1;
        tick(5);
        rd(3'd2, "hold_ctrl", 32'd0);
        rd(3'd3, "hold_baud", 32'd3);
        rd(3'd1, "hold_status", st(0, 1));
        tick(60);

        tick(4);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
